// File: rtl/input_conditioner_if.sv
// Button conditioner bus: raw buttons in, op pulses and debounced levels out.
interface input_conditioner_if;
  logic [3:0] op_raw;
  logic [3:0] op_out;
  logic [3:0] held;
  logic       busy;

  modport master (
    output op_raw,
    input  op_out,
    input  held,
    input  busy
  );

  modport slave (
    input  op_raw,
    output op_out,
    output held,
    output busy
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise, debounce and auto-repeat the four Tetris buttons, then
// serialise press events into single-cycle op pulses.
module input_conditioner #(
  parameter int         DEBOUNCE      = 20,
  parameter int         REPEAT_DELAY  = 300,
  parameter int         REPEAT_PERIOD = 100,
  parameter logic [3:0] REPEAT_MASK   = 4'b1101
) (
  input  logic                 clk,
  input  logic                 restart,
  input_conditioner_if.slave   bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_e;

  logic [3:0]    sync1_q;
  logic [3:0]    s_q;
  logic [3:0]    stable_q;
  logic [3:0]    pending_q;
  logic [3:0]    pending_d;
  logic [3:0]    op_q;
  logic          busy_q;
  logic [DW-1:0] db_q [4];
  logic [RW-1:0] rc_q [4];
  state_e        st_q [4];

  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rpt_hit;
  logic [3:0] ev;
  logic [3:0] grant;

  // Edges take effect on the same clock the stable level flips.
  always_comb begin
    rise    = '0;
    fall    = '0;
    rpt_hit = '0;
    ev      = '0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = s_q[i] & ~stable_q[i] &
                (db_q[i] == DW'(DEBOUNCE));
      fall[i] = ~s_q[i] & stable_q[i] &
                (db_q[i] == DW'(DEBOUNCE));
      rpt_hit[i] =
        ((st_q[i] == DELAY) &&
         (rc_q[i] == RW'(REPEAT_DELAY - 1))) ||
        ((st_q[i] == REPEAT) &&
         (rc_q[i] == RW'(REPEAT_PERIOD - 1)));
      ev[i] = rise[i] | (rpt_hit[i] & ~fall[i]);
    end
  end

  // Fixed priority: rotate > left > right > down.
  always_comb begin
    grant = '0;
    if (pending_q[1])      grant = 4'b0010;
    else if (pending_q[3]) grant = 4'b1000;
    else if (pending_q[0]) grant = 4'b0001;
    else if (pending_q[2]) grant = 4'b0100;
  end

  assign pending_d = (pending_q & ~grant) | ev;

  always_ff @(posedge clk) begin
    if (restart) begin
      sync1_q   <= '0;
      s_q       <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      op_q      <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        db_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.op_raw;
      s_q       <= sync1_q;
      pending_q <= pending_d;
      op_q      <= grant;
      busy_q    <= |pending_d;
      for (int i = 0; i < 4; i++) begin
        if (s_q[i] == stable_q[i]) begin
          db_q[i] <= '0;
        end else if (db_q[i] == DW'(DEBOUNCE)) begin
          db_q[i]     <= '0;
          stable_q[i] <= s_q[i];
        end else begin
          db_q[i] <= db_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i] <= IDLE;
        rc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fall[i]) begin
          st_q[i] <= IDLE;
          rc_q[i] <= '0;
        end else begin
          case (st_q[i])
            IDLE: begin
              rc_q[i] <= '0;
              if (rise[i] && REPEAT_MASK[i]) begin
                st_q[i] <= DELAY;
              end
            end
            DELAY: begin
              if (rpt_hit[i]) begin
                st_q[i] <= REPEAT;
                rc_q[i] <= '0;
              end else begin
                rc_q[i] <= rc_q[i] + RW'(1);
              end
            end
            REPEAT: begin
              if (rpt_hit[i]) begin
                rc_q[i] <= '0;
              end else begin
                rc_q[i] <= rc_q[i] + RW'(1);
              end
            end
            default: begin
              st_q[i] <= IDLE;
              rc_q[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.op_out = op_q;
  assign bus.held   = stable_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: scenario table, hand-written
// corner sequences and random stimulus against a behavioural model.
module tb_input_conditioner;

  localparam int         DEB  = 20;
  localparam int         RD   = 300;
  localparam int         RP   = 100;
  localparam logic [3:0] MASK = 4'b1101;
  localparam int         NOBS = 1024;

  logic clk = 1'b0;
  logic restart;

  input_conditioner_if bus ();

  input_conditioner dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = -1;

  logic [3:0] obs_op   [NOBS];
  logic [3:0] obs_held [NOBS];
  logic       obs_busy [NOBS];

  // Behavioural model state
  logic [3:0] m_sh1, m_sh2, m_stable, m_pend, m_out;
  logic       m_busy;
  int         m_diff [4];
  int         m_age  [4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (edge %0d)",
                 name, act, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    m_sh1 = '0; m_sh2 = '0; m_stable = '0;
    m_pend = '0; m_out = '0; m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_diff[i] = 0;
      m_age[i]  = -1;
    end
  endtask

  // One clock edge: age counts edges since the accepted press.
  task automatic model_edge(input logic [3:0] raw, input logic rst);
    logic [3:0] ev, gr;
    int prio [4];
    if (rst) begin
      model_clear();
      return;
    end
    prio = '{1, 3, 0, 2};
    gr = '0;
    for (int k = 0; k < 4; k++)
      if (gr == 0 && m_pend[prio[k]]) gr[prio[k]] = 1'b1;
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_sh2[i] != m_stable[i] && m_diff[i] == DEB) begin
        m_stable[i] = m_sh2[i];
        m_diff[i] = 0;
        if (m_stable[i]) begin
          m_age[i] = 0;
          ev[i] = 1'b1;
        end else begin
          m_age[i] = -1;
        end
      end else begin
        m_diff[i] = (m_sh2[i] != m_stable[i]) ? m_diff[i] + 1 : 0;
        if (m_age[i] >= 0) begin
          m_age[i]++;
          if (MASK[i] && m_age[i] >= RD && (m_age[i] - RD) % RP == 0)
            ev[i] = 1'b1;
        end
      end
    end
    m_out  = gr;
    m_pend = (m_pend & ~gr) | ev;
    m_busy = |m_pend;
    m_sh2  = m_sh1;
    m_sh1  = raw;
  endtask

  task automatic step();
    logic [3:0] raw;
    logic rst;
    raw = bus.op_raw;
    rst = restart;
    @(posedge clk);
    edge_n++;
    model_edge(raw, rst);
    #1;
    check("op_out", 32'(bus.op_out), 32'(m_out));
    check("held",   32'(bus.held),   32'(m_stable));
    check("busy",   32'(bus.busy),   32'(m_busy));
    if (edge_n >= 0 && edge_n < NOBS) begin
      obs_op[edge_n]   = bus.op_out;
      obs_held[edge_n] = bus.held;
      obs_busy[edge_n] = bus.busy;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    restart = 1'b1;
    bus.op_raw = '0;
    step();
    restart = 1'b0;
    edge_n = -1;
    for (int k = 0; k < NOBS; k++) begin
      obs_op[k] = '0;
      obs_held[k] = '0;
      obs_busy[k] = 1'b0;
    end
  endtask

  function automatic int count_pulses(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (obs_op[k] != 0) c++;
    return c;
  endfunction

  function automatic int first_pulse(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (obs_op[k] != 0) return k;
    return -1;
  endfunction

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] first_op;
    int         n_pulses;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{4'b0001, 50,  4'b0001, 1};
    vecs[1] = '{4'b0010, 600, 4'b0010, 1};
    vecs[2] = '{4'b0100, 600, 4'b0100, 4};
    vecs[3] = '{4'b1000, 350, 4'b1000, 2};
    vecs[4] = '{4'b1111, 30,  4'b0010, 4};
    vecs[5] = '{4'b0001, 10,  4'b0000, 0};

    model_clear();
    restart = 1'b1;
    bus.op_raw = '0;
    step();
    step();
    check("reset_op",   32'(bus.op_out), 32'h0);
    check("reset_held", 32'(bus.held),   32'h0);
    check("reset_busy", 32'(bus.busy),   32'h0);

    // Scenario table
    for (int v = 0; v < 6; v++) begin
      int fp;
      do_reset();
      bus.op_raw = vecs[v].raw;
      run(vecs[v].hold);
      bus.op_raw = '0;
      run(700 - vecs[v].hold);
      fp = first_pulse(0, 699);
      check($sformatf("vec%0d_count", v), 32'(count_pulses(0, 699)),
            32'(vecs[v].n_pulses));
      check($sformatf("vec%0d_first_op", v),
            32'((fp >= 0) ? obs_op[fp] : 4'b0000), 32'(vecs[v].first_op));
      if (vecs[v].n_pulses > 0)
        check($sformatf("vec%0d_first_edge", v), 32'(fp), 32'd23);
      if (v == 0) begin
        check("right_held22", 32'(obs_held[22][0]), 32'd1);
        check("right_held21", 32'(obs_held[21][0]), 32'd0);
        check("right_held71", 32'(obs_held[71][0]), 32'd1);
        check("right_held80", 32'(obs_held[80][0]), 32'd0);
      end
      if (v == 2) begin
        check("down_p323", 32'(obs_op[323]), 32'h4);
        check("down_p423", 32'(obs_op[423]), 32'h4);
        check("down_p523", 32'(obs_op[523]), 32'h4);
      end
      if (v == 4) begin
        check("sim_e23", 32'(obs_op[23]), 32'h2);
        check("sim_e24", 32'(obs_op[24]), 32'h8);
        check("sim_e25", 32'(obs_op[25]), 32'h1);
        check("sim_e26", 32'(obs_op[26]), 32'h4);
        check("sim_busy21", 32'(obs_busy[21]), 32'd0);
        for (int e = 22; e <= 25; e++)
          check($sformatf("sim_busy%0d", e), 32'(obs_busy[e]), 32'd1);
        check("sim_busy26", 32'(obs_busy[26]), 32'd0);
      end
    end

    // Bounce on left: 5-cycle toggles, then steady high from edge 40
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.op_raw = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      run(5);
    end
    bus.op_raw = 4'b1000;
    run(210);
    bus.op_raw = '0;
    run(60);
    check("bounce_quiet", 32'(count_pulses(0, 62)), 32'd0);
    check("bounce_pulse", 32'(obs_op[63]), 32'h8);
    check("bounce_count", 32'(count_pulses(0, 300)), 32'd1);

    // Restart mid-operation with left still held
    do_reset();
    bus.op_raw = 4'b1000;
    run(200);
    restart = 1'b1;
    step();
    restart = 1'b0;
    run(200);
    bus.op_raw = '0;
    check("rst_first",  32'(obs_op[23]),  32'h8);
    check("rst_held",   32'(obs_held[201]), 32'h0);
    check("rst_no323",  32'(obs_op[323]), 32'h0);
    check("rst_fresh",  32'(obs_op[224]), 32'h8);
    check("rst_count",  32'(count_pulses(0, 400)), 32'd2);
    run(40);

    // Random stimulus, model checked every cycle
    do_reset();
    for (int r = 0; r < 60; r++) begin
      int dur;
      bus.op_raw = 4'($urandom_range(0, 15));
      dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 450)
                                        : $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) begin
        restart = 1'b1;
        step();
        restart = 1'b0;
      end
      run(dur);
    end
    bus.op_raw = '0;
    run(50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
